// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI-framed register file, oversampled in the clk domain.
// Optional miso readback of read frames: define SPI_READBACK_EN.
module spi_reg_slave #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] result,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int REGS    = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        HOLD
    } state_t;

    state_t state;
    state_t state_n;

    logic sclk_s1, sclk_s2, sclk_q;
    logic ss_s1, ss_s2, ss_q;
    logic mosi_s1, mosi_s2;

    logic sclk_fall;
    logic ss_fall;
    logic ss_rise;
    logic bit_ok;

    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-2:0] shreg;
    logic [FRAME_W-1:0] word;

    logic               w_rw;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;

    logic start;
    logic take;
    logic hdr_end;
    logic commit;
    logic abort;

    logic [DATA_W-1:0] regs [REGS];

    // Two-flop synchronisers plus one extra stage for edge detection
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_q  <= 1'b0;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_q    <= 1'b1;
            mosi_s1 <= 1'b1;
            mosi_s2 <= 1'b1;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_q  <= sclk_s2;
            ss_s1   <= ss;
            ss_s2   <= ss_s1;
            ss_q    <= ss_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_fall = sclk_q & ~sclk_s2;
    assign ss_fall   = ss_q & ~ss_s2;
    assign ss_rise   = ~ss_q & ss_s2;

    // ss_q low means select was held up to this clk, so a final bit
    // landing on the same clk as ss rising is still accepted
    assign bit_ok = sclk_fall & ~ss_q;

    assign word   = {shreg, mosi_s2};
    assign w_rw   = word[FRAME_W-1];
    assign w_addr = word[DATA_W +: ADDR_W];
    assign w_data = word[DATA_W-1:0];

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and frame control strobes
    always_comb begin
        state_n = state;
        start   = 1'b0;
        take    = 1'b0;
        hdr_end = 1'b0;
        commit  = 1'b0;
        abort   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_fall) begin
                    start   = 1'b1;
                    state_n = HDR;
                end
            end
            HDR: begin
                if (ss_rise) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end else if (bit_ok) begin
                    take = 1'b1;
                    if (cnt == CNT_W'(ADDR_W)) begin
                        hdr_end = 1'b1;
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_ok && cnt == CNT_W'(FRAME_W - 1)) begin
                    commit  = 1'b1;
                    state_n = ss_rise ? IDLE : HOLD;
                end else if (ss_rise) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end else if (bit_ok) begin
                    take = 1'b1;
                end
            end
            HOLD: begin
                if (ss_rise) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Bit counter and receive shift register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (start) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (take) begin
            cnt   <= cnt + CNT_W'(1);
            shreg <= {shreg[FRAME_W-3:0], mosi_s2};
        end
    end

    // Register file, result and completion pulses
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
            result     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= commit;
            frame_err  <= abort;
            if (commit) begin
                if (!w_rw) begin
                    regs[w_addr] <= w_data;
                    result       <= w_data;
                end else begin
                    result <= regs[w_addr];
                end
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic              sclk_rise;
    logic [ADDR_W:0]   hdr;
    logic [DATA_W-1:0] tx;

    assign sclk_rise = ~sclk_q & sclk_s2;
    assign hdr       = {shreg[ADDR_W-1:0], mosi_s2};

    // Load read data when the header completes, shift on each sclk rise
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx <= '0;
        end else if (hdr_end) begin
            tx <= hdr[ADDR_W] ? regs[hdr[ADDR_W-1:0]] : '0;
        end else if (state == DATA && sclk_rise) begin
            tx <= {tx[DATA_W-2:0], 1'b0};
        end
    end

    assign miso = (state == DATA) & tx[DATA_W-1];
`else
    assign miso = 1'b0;
`endif

endmodule
